// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame_tx byte framer.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LEN,
    ST_PAY,
    ST_SUM
  } state_t;

  localparam logic [31:0] PREAMBLE_DEFAULT = 32'hF0AA550F;

  localparam int unsigned PRE_BYTES = 4;
  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned SUM_BYTES = 1;

endpackage

// File: rtl/word_serializer.sv
// One-word holding buffer that hands a 32-bit word out as four bytes, LSB first.
module word_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word,
  input  logic        word_take,
  output logic        full,
  output logic [7:0]  byte_data,
  output logic        byte_vld,
  output logic        byte_last,
  input  logic        byte_take
);

  logic [31:0] hold;
  logic [1:0]  idx;

  // Byte 0 bypasses the holding register so a word accepted while the output
  // register is free costs no bubble.
  assign byte_vld  = full | word_take;
  assign byte_last = full & (idx == 2'd3);
  assign byte_data = full ? hold[{idx, 3'b000} +: 8] : word[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      idx  <= '0;
      full <= 1'b0;
    end else if (word_take) begin
      hold <= word;
      full <= 1'b1;
      idx  <= byte_take ? 2'd1 : 2'd0;
    end else if (full && byte_take) begin
      if (idx == 2'd3) full <= 1'b0;
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// Wraps the scope word stream into a preamble/length/payload/checksum byte packet.
//   state | meaning
//   IDLE  | waiting for a rising edge of i_frame_ready
//   PRE   | loading preamble bytes 1..3 (byte 0 is loaded on the start edge)
//   LEN   | loading frame size, LSB first
//   PAY   | loading payload bytes from the word serializer
//   SUM   | cnt 0: load checksum; cnt 1: wait for its handshake
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter logic [31:0] PREAMBLE = PREAMBLE_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_frame_ready,
  input  logic [15:0] i_frame_size,
  input  logic [31:0] i_data,
  input  logic        i_vld,
  output logic        o_rdy,
  output logic [7:0]  o_byte,
  output logic        o_byte_vld,
  input  logic        i_byte_rdy,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [15:0] words_left, words_nxt;
  logic [7:0]  sum, sum_nxt;
  logic [7:0]  byte_q, byte_nxt;
  logic        byte_vld_q, vld_nxt;
  logic        done_q, done_nxt;
  logic        overrun_q, overrun_nxt;
  logic        ready_q;

  logic        start_edge;
  logic        load;
  logic        word_take;
  logic        full;
  logic [7:0]  ser_byte;
  logic        ser_vld;
  logic        ser_last;
  logic        ser_take;
  logic [1:0]  pidx;

  assign start_edge = i_frame_ready & ~ready_q;
  // Output register may take a new byte when empty or being drained this cycle.
  assign load       = ~byte_vld_q | i_byte_rdy;
  assign o_rdy      = (state == ST_PAY) & (words_left != 16'd0) & ~full;
  assign word_take  = i_vld & o_rdy;
  assign pidx       = 2'd3 - cnt;

  word_serializer u_ser (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .word      (i_data),
    .word_take (word_take),
    .full      (full),
    .byte_data (ser_byte),
    .byte_vld  (ser_vld),
    .byte_last (ser_last),
    .byte_take (ser_take)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    words_nxt   = words_left;
    sum_nxt     = sum;
    byte_nxt    = byte_q;
    vld_nxt     = byte_vld_q;
    done_nxt    = 1'b0;
    overrun_nxt = start_edge & (state != ST_IDLE);
    ser_take    = 1'b0;

    if (word_take) words_nxt = words_left - 16'd1;

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nxt = ST_PRE;
          cnt_nxt   = 2'd1;
          words_nxt = i_frame_size;
          sum_nxt   = '0;
          byte_nxt  = PREAMBLE[31:24];
          vld_nxt   = 1'b1;
        end
      end
      ST_PRE: begin
        if (load) begin
          byte_nxt = PREAMBLE[{pidx, 3'b000} +: 8];
          vld_nxt  = 1'b1;
          if (cnt == 2'(PRE_BYTES - 1)) begin
            state_nxt = ST_LEN;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
      end
      ST_LEN: begin
        if (load) begin
          byte_nxt = (cnt == 2'd0) ? words_left[7:0] : words_left[15:8];
          sum_nxt  = sum + byte_nxt;
          vld_nxt  = 1'b1;
          if (cnt == 2'(LEN_BYTES - 1)) begin
            state_nxt = (words_left == 16'd0) ? ST_SUM : ST_PAY;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
      end
      ST_PAY: begin
        if (load) begin
          if (ser_vld) begin
            byte_nxt = ser_byte;
            sum_nxt  = sum + ser_byte;
            vld_nxt  = 1'b1;
            ser_take = 1'b1;
            if (ser_last && (words_left == 16'd0)) begin
              state_nxt = ST_SUM;
              cnt_nxt   = 2'd0;
            end
          end else begin
            vld_nxt = 1'b0;
          end
        end
      end
      ST_SUM: begin
        if (cnt == 2'd0) begin
          if (load) begin
            byte_nxt = sum;
            vld_nxt  = 1'b1;
            cnt_nxt  = 2'd1;
          end
        end else if (i_byte_rdy) begin
          vld_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = 2'd0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      words_left <= '0;
      sum        <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      words_left <= words_nxt;
      sum        <= sum_nxt;
      byte_q     <= byte_nxt;
      byte_vld_q <= vld_nxt;
      done_q     <= done_nxt;
      overrun_q  <= overrun_nxt;
      ready_q    <= i_frame_ready;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_vld   = byte_vld_q;
  assign o_busy       = (state != ST_IDLE);
  assign o_frame_done = done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx with a byte scoreboard and random stall drivers.
module tb_frame_tx;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_ready = 1'b0;
  logic [15:0] i_frame_size = '0;
  logic [31:0] i_data = '0;
  logic        i_vld = 1'b0;
  logic        o_rdy;
  logic [7:0]  o_byte;
  logic        o_byte_vld;
  logic        i_byte_rdy = 1'b0;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_pct = 100;
  int gap_pct = 0;
  int words_acc = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int done_cyc = 0;
  logic rdy_seen = 1'b0;

  logic [7:0]  exp_q[$];
  logic [31:0] src_q[$];
  int          hs_cyc[$];

  frame_tx dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .i_frame_ready(i_frame_ready),
    .i_frame_size (i_frame_size),
    .i_data       (i_data),
    .i_vld        (i_vld),
    .o_rdy        (o_rdy),
    .o_byte       (o_byte),
    .o_byte_vld   (o_byte_vld),
    .i_byte_rdy   (i_byte_rdy),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready driver.
  always begin
    @(posedge sys_clk);
    #1;
    i_byte_rdy = ($urandom_range(0, 99) < rdy_pct);
  end

  // Upstream word source with random gaps.
  always begin
    logic        take;
    logic [31:0] dummy;
    @(negedge sys_clk);
    take = i_vld && o_rdy && rst_n;
    @(posedge sys_clk);
    #1;
    if (take && src_q.size() > 0) begin
      dummy = src_q.pop_front();
      words_acc++;
    end
    if (src_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      i_vld  = 1'b1;
      i_data = src_q[0];
    end else begin
      i_vld = 1'b0;
    end
  end

  // Output monitor: scoreboard compare, stall stability, pulse counting.
  always begin
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic [7:0] exp_b;
    prev_stall = 1'b0;
    prev_byte  = '0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_vld", 32'(o_byte_vld), 32'd1);
          check("stall_byte", 32'(o_byte), 32'(prev_byte));
        end
        if (o_byte_vld && i_byte_rdy) begin
          hs_cyc.push_back(cyc);
          check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("byte", 32'(o_byte), 32'(exp_b));
          end
        end
        if (o_frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (o_overrun) ovr_cnt++;
        if (o_rdy) rdy_seen = 1'b1;
        prev_stall = o_byte_vld & ~i_byte_rdy;
        prev_byte  = o_byte;
      end
    end
  end

  // Reference packet: expected bytes go to the scoreboard, words to the source.
  task automatic queue_frame(input int size, input int offered, input logic [7:0] seed);
    logic [7:0]  s, b;
    logic [31:0] w;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'(size));
    exp_q.push_back(8'(size >> 8));
    s = 8'(size) + 8'(size >> 8);
    for (int i = 0; i < offered; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        b = seed + 8'(4 * i + k + 1);
        w[8*k +: 8] = b;
        if (i < size) begin
          exp_q.push_back(b);
          s = s + b;
        end
      end
      src_q.push_back(w);
    end
    exp_q.push_back(s);
  endtask

  task automatic raise_ready(input int size);
    @(posedge sys_clk);
    #1;
    i_frame_size  = 16'(size);
    i_frame_ready = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while ((exp_q.size() != 0 || o_busy !== 1'b0) && n < budget);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge sys_clk);
    check("rst_rdy", 32'(o_rdy), 0);
    check("rst_byte", 32'(o_byte), 0);
    check("rst_byte_vld", 32'(o_byte_vld), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_frame_done), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Size 2, no stalls.
    hs_cyc.delete();
    done_cnt = 0;
    words_acc = 0;
    queue_frame(2, 2, 8'h00);
    raise_ready(2);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("start_busy", 32'(o_busy), 1);
    check("start_vld", 32'(o_byte_vld), 1);
    check("start_byte", 32'(o_byte), 32'hF0);
    wait_idle("s2_complete", 200);
    check("s2_done_cnt", done_cnt, 1);
    check("s2_bytes", hs_cyc.size(), 15);
    if (hs_cyc.size() == 15) begin
      check("s2_span", hs_cyc[14] - hs_cyc[0], 14);
      check("s2_done_timing", done_cyc - hs_cyc[14], 1);
    end
    check("s2_words", words_acc, 2);
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Size 0.
    done_cnt = 0;
    rdy_seen = 1'b0;
    queue_frame(0, 0, 8'h00);
    raise_ready(0);
    wait_idle("s0_complete", 200);
    check("s0_rdy_never", 32'(rdy_seen), 0);
    check("s0_done_cnt", done_cnt, 1);
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Size 64 with random stalls on both sides and 6 excess words offered.
    done_cnt = 0;
    words_acc = 0;
    rdy_pct = 30;
    gap_pct = 30;
    queue_frame(64, 70, 8'($urandom));
    raise_ready(64);
    wait_idle("s64_complete", 5000);
    check("s64_words", words_acc, 64);
    check("s64_leftover", src_q.size(), 6);
    check("s64_done_cnt", done_cnt, 1);
    src_q.delete();
    rdy_pct = 100;
    gap_pct = 0;
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    repeat (3) @(posedge sys_clk);

    // Second rising edge during PAY.
    done_cnt = 0;
    ovr_cnt = 0;
    queue_frame(8, 8, 8'h30);
    raise_ready(8);
    repeat (10) @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b1;
    wait_idle("ovr_complete", 300);
    repeat (15) @(negedge sys_clk);
    check("ovr_cnt", ovr_cnt, 1);
    check("ovr_done_cnt", done_cnt, 1);
    check("ovr_no_restart", 32'(o_busy), 0);
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Reset during PAY, then a clean frame.
    queue_frame(8, 8, 8'h50);
    raise_ready(8);
    repeat (12) @(posedge sys_clk);
    @(negedge sys_clk);
    check("prerst_busy", 32'(o_busy), 1);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    i_frame_ready = 1'b0;
    #1;
    check("midrst_rdy", 32'(o_rdy), 0);
    check("midrst_byte", 32'(o_byte), 0);
    check("midrst_vld", 32'(o_byte_vld), 0);
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_done", 32'(o_frame_done), 0);
    check("midrst_ovr", 32'(o_overrun), 0);
    exp_q.delete();
    src_q.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    done_cnt = 0;
    queue_frame(1, 1, 8'h70);
    raise_ready(1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("postrst_first", 32'(o_byte), 32'hF0);
    wait_idle("postrst_complete", 200);
    check("postrst_done_cnt", done_cnt, 1);
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    repeat (2) @(posedge sys_clk);

    // Back-to-back size-1 frames.
    hs_cyc.delete();
    done_cnt = 0;
    queue_frame(1, 1, 8'h40);
    queue_frame(1, 1, 8'h80);
    raise_ready(1);
    repeat (3) @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    begin
      int n;
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (o_busy !== 1'b0 && n < 100);
      check("b2b_first_end", 32'(o_busy), 0);
    end
    i_frame_ready = 1'b1;
    wait_idle("b2b_complete", 200);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_bytes", hs_cyc.size(), 22);
    if (hs_cyc.size() == 22) check("b2b_gap", hs_cyc[11] - hs_cyc[10], 2);
    @(posedge sys_clk);
    #1;
    i_frame_ready = 1'b0;
    repeat (3) @(posedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
